// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: 2-FF sync, tick-sampled qualification, clean level plus rise/fall strobes.
// Latency: 2 sync cycles plus STABLE_TICKS sample ticks from a clean edge to the level change; all outputs registered.
// No backpressure: free-running, en=0 freezes the prescaler and all qualification state.
module debounce_bank #(
    parameter int   CHANNELS     = 4,
    parameter int   DIVISOR      = 24000,
    parameter int   STABLE_TICKS = 50,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic                clk_24M,
    input  logic                reset_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] btn_in,
    output logic                tick,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall
);

    // Prescaler counter width; guarded so a degenerate divisor still yields a 1-bit counter.
    localparam int              PW         = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIVISOR - 1);

    // Stable counter carries one spare bit so STABLE_TICKS-1 always fits, including STABLE_TICKS=1.
    localparam int              CW         = $clog2(STABLE_TICKS) + 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [PW-1:0]       presc_cnt;
    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_q;
    logic                sample;

    // Prescaler: count 0..DIVISOR-1 and raise tick for the single cycle after the wrap; frozen while en=0.
    always_ff @(posedge clk_24M or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            tick      <= 1'b0;
        end else if (en) begin
            if (presc_cnt == PRESC_LAST) begin
                presc_cnt <= '0;
                tick      <= 1'b1;
            end else begin
                presc_cnt <= presc_cnt + PW'(1);
                tick      <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous button pins; runs regardless of en so it never holds stale data.
    always_ff @(posedge clk_24M or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= {CHANNELS{INIT_LEVEL}};
            sync_q    <= {CHANNELS{INIT_LEVEL}};
        end else begin
            sync_meta <= btn_in;
            sync_q    <= sync_meta;
        end
    end

    // A tick that lands in a cycle where en has just dropped is ignored, so freezing is immediate.
    assign sample = tick & en;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CW-1:0] stable_cnt;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;

        // Qualification: count consecutive differing samples, accept the new level on the last one, emit a strobe.
        always_ff @(posedge clk_24M or negedge reset_n) begin
            if (!reset_n) begin
                stable_cnt <= '0;
                level_q    <= INIT_LEVEL;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sample) begin
                    if (sync_q[i] == level_q) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == CNT_LAST) begin
                        stable_cnt <= '0;
                        level_q    <= sync_q[i];
                        rise_q     <= sync_q[i];
                        fall_q     <= ~sync_q[i];
                    end else begin
                        stable_cnt <= stable_cnt + CW'(1);
                    end
                end
            end
        end

        assign btn_level[i] = level_q;
        assign btn_rise[i]  = rise_q;
        assign btn_fall[i]  = fall_q;
    end

endmodule
